// File: rtl/i2cmb_wb_cmd_sequencer_if.sv
// rtl/i2cmb_wb_cmd_sequencer_if.sv - request, byte stream and Wishbone signal bundle for the I2CMB command sequencer
// master = the sequencer (Wishbone master); slave = stimulus logic plus the I2CMB core.
interface i2cmb_wb_cmd_sequencer_if #(
    parameter int NUM_BUSES = 16,
    parameter int MAX_BYTES = 64
);
    localparam int BUS_W = $clog2(NUM_BUSES);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    logic             req_valid_i;
    logic             req_ready_o;
    logic [BUS_W-1:0] req_bus_i;
    logic [6:0]       req_addr_i;
    logic             req_rnw_i;
    logic [LEN_W-1:0] req_len_i;
    logic             req_restart_i;
    logic             req_irq_mode_i;
    logic             wdata_valid_i;
    logic [7:0]       wdata_i;
    logic             wdata_ready_o;
    logic             rdata_valid_o;
    logic [7:0]       rdata_o;
    logic             done_o;
    logic [2:0]       status_o;
    logic [1:0]       wb_adr_o;
    logic [7:0]       wb_dat_o;
    logic [7:0]       wb_dat_i;
    logic             wb_we_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_ack_i;
    logic             irq_i;

    modport master (
        input  req_valid_i, req_bus_i, req_addr_i, req_rnw_i, req_len_i,
               req_restart_i, req_irq_mode_i, wdata_valid_i, wdata_i,
               wb_dat_i, wb_ack_i, irq_i,
        output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o,
               status_o, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output req_valid_i, req_bus_i, req_addr_i, req_rnw_i, req_len_i,
               req_restart_i, req_irq_mode_i, wdata_valid_i, wdata_i,
               wb_dat_i, wb_ack_i, irq_i,
        input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o,
               status_o, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/i2cmb_wb_cmd_sequencer.sv
// rtl/i2cmb_wb_cmd_sequencer.sv - expands one I2C transfer request into the I2CMB CSR/DPR/CMDR Wishbone sequence
// Every beat-issuing state raises cyc/stb itself; the ack moves the FSM on, which leaves one idle cycle between beats.
module i2cmb_wb_cmd_sequencer #(
    parameter int NUM_BUSES   = 16,
    parameter int MAX_BYTES   = 64,
    parameter int CMD_TIMEOUT = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    i2cmb_wb_cmd_sequencer_if.master bus
);
    localparam int BUS_W = $clog2(NUM_BUSES);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam int TMO_W = $clog2(CMD_TIMEOUT + 1);

    localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;
    localparam logic [2:0] C_WRITE = 3'b001, C_READ_ACK = 3'b010, C_READ_NAK = 3'b011;
    localparam logic [2:0] C_START = 3'b100, C_STOP = 3'b101, C_SET_BUS = 3'b110;
    localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2, ST_ERR = 3'd3, ST_TMO = 3'd4;

    typedef enum logic [4:0] {
        S_IDLE, S_CSR, S_PSTOP, S_SB_DPR, S_SB_CMD, S_START, S_A_DPR, S_A_CMD,
        S_W_STALL, S_W_DPR, S_W_CMD, S_R_CMD, S_R_DPR, S_STOP, S_WAIT_IRQ, S_POLL, S_DONE
    } state_t;

    state_t           r_state, r_wret;
    logic [BUS_W-1:0] r_bus, r_cache_bus;
    logic [6:0]       r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_wbyte, r_rdata, r_dat;
    logic [2:0]       r_status;
    logic [1:0]       r_adr;
    logic r_rnw, r_restart, r_irq, r_core_en, r_core_irq, r_cache_vld, r_held, r_nak, r_tmo_run;
    logic r_ready, r_wready, r_rvalid, r_done, r_we, r_cyc;

    logic       w_issue, w_we, w_cmd;
    logic [1:0] w_adr;
    logic [7:0] w_dat;
    state_t     w_wait, w_tail;

    always_comb begin
        w_issue = 1'b1;
        w_we    = 1'b1;
        w_adr   = A_CMDR;
        w_dat   = 8'h00;
        case (r_state)
            S_CSR:            begin w_adr = A_CSR; w_dat = r_irq ? 8'hC0 : 8'h80; end
            S_PSTOP, S_STOP:  w_dat = {5'd0, C_STOP};
            S_SB_DPR:         begin w_adr = A_DPR; w_dat = 8'(r_bus); end
            S_SB_CMD:         w_dat = {5'd0, C_SET_BUS};
            S_START:          w_dat = {5'd0, C_START};
            S_A_DPR:          begin w_adr = A_DPR; w_dat = {r_addr, r_rnw}; end
            S_A_CMD, S_W_CMD: w_dat = {5'd0, C_WRITE};
            S_W_DPR:          begin w_adr = A_DPR; w_dat = r_wbyte; end
            S_R_CMD:          w_dat = {5'd0, (r_cnt == LEN_W'(1)) ? C_READ_NAK : C_READ_ACK};
            S_R_DPR:          begin w_we = 1'b0; w_adr = A_DPR; end
            S_POLL:           w_we = 1'b0;
            default:          w_issue = 1'b0;
        endcase
    end

    assign w_cmd  = w_issue && w_we && (w_adr == A_CMDR);
    assign w_wait = r_irq ? S_WAIT_IRQ : S_POLL;
    assign w_tail = r_restart ? S_DONE : S_STOP;

    // A different held bus must be released before SET_BUS; the cached bus skips SET_BUS entirely.
    function automatic state_t f_route(input logic [BUS_W-1:0] b);
        if (r_held && b != r_cache_bus)          return S_PSTOP;
        else if (!r_cache_vld || b != r_cache_bus) return S_SB_DPR;
        else                                      return S_START;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;   r_wret <= S_IDLE;
            r_bus <= '0;         r_cache_bus <= '0;  r_addr <= '0;   r_cnt <= '0;
            r_tmo <= '0;         r_wbyte <= '0;      r_rdata <= '0;  r_dat <= '0;
            r_status <= '0;      r_adr <= '0;        r_rnw <= 1'b0;  r_restart <= 1'b0;
            r_irq <= 1'b0;       r_core_en <= 1'b0;  r_core_irq <= 1'b0;
            r_cache_vld <= 1'b0; r_held <= 1'b0;     r_nak <= 1'b0;  r_tmo_run <= 1'b0;
            r_ready <= 1'b0;     r_wready <= 1'b0;   r_rvalid <= 1'b0;
            r_done <= 1'b0;      r_we <= 1'b0;       r_cyc <= 1'b0;
        end else begin
            r_ready  <= 1'b0;
            r_wready <= 1'b0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            if (r_tmo_run) r_tmo <= r_tmo + TMO_W'(1);

            if (r_tmo_run && r_tmo >= TMO_W'(CMD_TIMEOUT - 1)) begin
                r_cyc <= 1'b0;  r_we <= 1'b0;  r_tmo_run <= 1'b0;  r_core_en <= 1'b0;
                r_status <= ST_TMO;  r_done <= 1'b1;  r_state <= S_IDLE;
            end else if (w_issue && !r_cyc) begin
                r_cyc <= 1'b1;  r_we <= w_we;  r_adr <= w_adr;  r_dat <= w_dat;
                if (w_cmd) begin r_tmo <= TMO_W'(1); r_tmo_run <= 1'b1; end
            end else if (r_cyc) begin
                if (bus.wb_ack_i) begin
                    r_cyc <= 1'b0;
                    r_we  <= 1'b0;
                    case (r_state)
                        S_CSR:    begin r_core_en <= 1'b1; r_core_irq <= r_irq; r_state <= f_route(r_bus); end
                        S_PSTOP:  begin r_held <= 1'b0; r_wret <= S_SB_DPR; r_state <= w_wait; end
                        S_SB_DPR: r_state <= S_SB_CMD;
                        S_SB_CMD: begin r_cache_vld <= 1'b1; r_cache_bus <= r_bus; r_wret <= S_START; r_state <= w_wait; end
                        S_START:  begin r_wret <= S_A_DPR; r_state <= w_wait; end
                        S_A_DPR:  r_state <= S_A_CMD;
                        S_A_CMD:  begin r_wret <= r_rnw ? S_R_CMD : S_W_STALL; r_state <= w_wait; end
                        S_W_DPR:  r_state <= S_W_CMD;
                        S_W_CMD: begin
                            r_wret  <= (r_cnt == LEN_W'(1)) ? w_tail : S_W_STALL;
                            r_cnt   <= r_cnt - LEN_W'(1);
                            r_state <= w_wait;
                        end
                        S_R_CMD:  begin r_wret <= S_R_DPR; r_state <= w_wait; end
                        S_R_DPR: begin
                            r_rdata  <= bus.wb_dat_i;
                            r_rvalid <= 1'b1;
                            r_cnt    <= r_cnt - LEN_W'(1);
                            r_state  <= (r_cnt == LEN_W'(1)) ? w_tail : S_R_CMD;
                        end
                        S_STOP:   begin r_held <= 1'b0; r_wret <= S_DONE; r_state <= w_wait; end
                        S_POLL: begin
                            // AL > ERR > NAK > DON; a NAK seen while already stopping after a NAK counts as done
                            if (bus.wb_dat_i[5]) begin
                                r_status <= ST_AL; r_held <= 1'b0; r_done <= 1'b1;
                                r_tmo_run <= 1'b0; r_state <= S_IDLE;
                            end else if (bus.wb_dat_i[4]) begin
                                r_status <= ST_ERR; r_done <= 1'b1;
                                r_tmo_run <= 1'b0; r_state <= S_IDLE;
                            end else if (bus.wb_dat_i[6] && !r_nak) begin
                                r_nak <= 1'b1; r_tmo_run <= 1'b0; r_state <= S_STOP;
                            end else if (bus.wb_dat_i[7] || bus.wb_dat_i[6]) begin
                                r_tmo_run <= 1'b0; r_state <= r_wret;
                            end else begin
                                r_state <= w_wait;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_ready && bus.req_valid_i) begin
                            r_bus     <= bus.req_bus_i;
                            r_addr    <= bus.req_addr_i;
                            r_rnw     <= bus.req_rnw_i;
                            r_cnt     <= (bus.req_len_i == '0) ? LEN_W'(1) : bus.req_len_i;
                            r_restart <= bus.req_restart_i;
                            r_irq     <= bus.req_irq_mode_i;
                            r_nak     <= 1'b0;
                            r_state   <= (!r_core_en || r_core_irq != bus.req_irq_mode_i)
                                         ? S_CSR : f_route(bus.req_bus_i);
                        end else begin
                            r_ready <= 1'b1;
                        end
                    end
                    S_W_STALL: if (bus.wdata_valid_i) begin
                        r_wbyte  <= bus.wdata_i;
                        r_wready <= 1'b1;
                        r_state  <= S_W_DPR;
                    end
                    S_WAIT_IRQ: if (bus.irq_i) r_state <= S_POLL;
                    S_DONE: begin
                        r_done   <= 1'b1;
                        r_status <= r_nak ? ST_NAK : ST_OK;
                        if (r_restart && !r_nak) r_held <= 1'b1;
                        r_nak    <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.req_ready_o   = r_ready;
    assign bus.wdata_ready_o = r_wready;
    assign bus.rdata_valid_o = r_rvalid;
    assign bus.rdata_o       = r_rdata;
    assign bus.done_o        = r_done;
    assign bus.status_o      = r_status;
    assign bus.wb_adr_o      = r_adr;
    assign bus.wb_dat_o      = r_dat;
    assign bus.wb_we_o       = r_we;
    assign bus.wb_cyc_o      = r_cyc;
    assign bus.wb_stb_o      = r_cyc;
endmodule

// File: doc/i2cmb_wb_cmd_sequencer.md
Name: i2cmb_wb_cmd_sequencer

Overview:
- Wishbone master that turns one I2C transfer request (bus, 7-bit address, direction, length, restart/stop) into the full I2CMB register command sequence.
- Register map: CSR=0, DPR=1, CMDR=2.
- Sits between test/stimulus logic and the I2CMB core's Wishbone slave port.
- Generalises the fixed command set: multi-bus, multi-byte bursts, runtime IRQ/poll completion, repeated start, bus caching and a completion timeout.

Parameters:
- NUM_BUSES, 16, number of selectable I2C buses; BUS_W = $clog2(NUM_BUSES).
- MAX_BYTES, 64, maximum data bytes per request; LEN_W = $clog2(MAX_BYTES+1).
- CMD_TIMEOUT, 65535, cycles allowed per command completion before abort.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_bus_i  in  BUS_W  target bus id
- req_addr_i  in  7  I2C slave address
- req_rnw_i  in  1  1=read, 0=write
- req_len_i  in  LEN_W  byte count, 1..MAX_BYTES
- req_restart_i  in  1  1=end without STOP (repeated start follows)
- req_irq_mode_i  in  1  1=wait on irq_i, 0=poll CMDR
- wdata_valid_i  in  1  write byte valid
- wdata_i  in  8  write byte
- wdata_ready_o  out  1  write byte consumed
- rdata_valid_o  out  1  one-cycle read byte strobe
- rdata_o  out  8  read byte
- done_o  out  1  one-cycle completion pulse
- status_o  out  3  0=OK, 1=NAK, 2=ARB_LOST, 3=CORE_ERR, 4=TIMEOUT (valid with done_o, held after)
- wb_adr_o  out  2  register address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- irq_i  in  1  core interrupt

Behaviour:
- Reset: all outputs 0. Internal state cleared: core_enabled=0, bus_cached invalid, bus_held=0, FSM=IDLE. Reset mid-transfer drops cyc/stb in the same cycle it asserts.
- WB beat:
  - cyc/stb/we/adr/dat assert together and hold until the cycle ack_i=1.
  - Deassert the next cycle; minimum one idle cycle between beats.
  - Read data captured from wb_dat_i on the ack cycle.
- req_ready_o=1 only in IDLE. On accept, all req_* fields are latched; irq mode is fixed for the whole request.
- Sequence on accept:
  - a) If !core_enabled or mode changed: CSR write 0xC0 (irq) or 0x80 (poll), then set core_enabled.
  - b) If bus_held and req_bus_i != held bus: STOP first.
  - c) If req_bus_i != cached bus: DPR=bus, CMDR=SET_BUS (3'b110), WAIT.
  - d) CMDR=START (100), WAIT.
  - e) DPR={addr,rnw}, CMDR=WRITE (001), WAIT.
  - f) Per byte, write direction: stall until wdata_valid_i, pulse wdata_ready_o one cycle, DPR=byte, CMDR=WRITE, WAIT.
  - f) Per byte, read direction: CMDR=READ_ACK (010), or READ_NACK (011) on the last byte; WAIT; DPR read; rdata_valid_o pulses one cycle after the ack with rdata_o=captured byte.
  - g) If !restart: CMDR=STOP (101), WAIT, bus_held=0. Else bus_held=1.
  - h) done_o pulse, status=OK, return to IDLE.
- WAIT state:
  - Poll mode: repeated CMDR reads until any of bit7 DON, bit6 NAK, bit5 AL, bit4 ERR is set.
  - IRQ mode: idle until irq_i=1, then one CMDR read; that read clears the irq.
  - Priority when several bits are set: AL > ERR > NAK > DON.
- Abort handling:
  - NAK: issue STOP, then done, status=1.
  - AL: no STOP, bus_held=0, status=2.
  - ERR: status=3, no STOP.
  - Timeout: cycle counter runs from command issue; at CMD_TIMEOUT with no completion, drop the WB beat if open, status=4, core_enabled=0 so the next request re-enables.
- req_len_i=0 is treated as 1.
- Byte counter is LEN_W bits and decrements to 0; no wrap.
- NACK selection uses count==1.
- Write stall on wdata_valid_i has no timeout.

Test Plan:
- Poll write, bus 3, addr 0x22, len 2, data 0xA5,0x5A -> WB writes in order: CSR=0x80, DPR=3, CMDR=6, CMDR=4, DPR=0x44, CMDR=1, DPR=0xA5, CMDR=1, DPR=0x5A, CMDR=1, CMDR=5; done_o with status 0.
- IRQ read, len 3, slave returns 0x11,0x22,0x33 -> CMDR=2,2,3; rdata strobes 0x11,0x22,0x33; CMDR read only after irq_i; status 0.
- Second request on the same bus -> no SET_BUS beat. Restart request then a different-bus request -> STOP precedes DPR=new bus.
- Address NAK (CMDR reads 0x40) -> STOP issued, status 1, no data beats.
- CMDR returns 0x20 mid-write -> no STOP, status 2. Core never completes with CMD_TIMEOUT=100 -> done at cycle 100, status 4, next request rewrites CSR.
- rst_i asserted while a WB beat is open -> cyc_o/stb_o low immediately; after release, the first request rewrites CSR and SET_BUS.
